// File: rtl/note_pkg.sv
// Shared definitions for the note detector: note codes, nominal half-period
// table (CLK cycles at 100 MHz) and the FSM state encoding.
package note_pkg;

  localparam int NUM_NOTES = 8;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } note_state_e;

  function automatic int unsigned nom_half_period(logic [3:0] code);
    case (code)
      NOTE_C4: return 32'd191110;
      NOTE_D4: return 32'd170266;
      NOTE_E4: return 32'd151685;
      NOTE_F4: return 32'd143172;
      NOTE_G4: return 32'd127551;
      NOTE_A4: return 32'd113636;
      NOTE_B4: return 32'd101215;
      NOTE_C5: return 32'd95602;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for the tone pin plus a third stage; edge_o flags
// either transition for one CLK cycle.
module tone_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic tone_i,
  output logic edge_o
);

  logic [2:0] sync_q;

  // NOTE: non-blocking assignments so every stage samples its pre-edge value.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], tone_i};
  end

  assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/note_detector.sv
// Measures tone half-periods and decodes them to scale notes C4..C5.
// Define NOTE_DETECT_DEBUG_EN to expose the raw measurement on HALF_PERIOD.
// NOM_SHIFT scales the nominal table down (0 = real 100 MHz values).
module note_detector
  import note_pkg::*;
#(
  parameter int TOL_SHIFT = 6,
  parameter int CNT_W     = 18,
  parameter int NOM_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TONE_IN,
  output logic [3:0]       NOTE_CODE,
  output logic             NOTE_VALID,
  output logic             NOTE_STROBE
`ifdef NOTE_DETECT_DEBUG_EN
  ,
  output logic [CNT_W-1:0] HALF_PERIOD
`endif
);

  localparam int              EXT_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             edge_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, meas_q;
  logic             cnt_sat, meas_vld_q, meas_sat_q, cls_vld_q;
  logic [3:0]       cls_q, cls_d, cand_q, cand_d, code_q, code_d;
  logic             valid_q, strobe_q;
  note_state_e      state_q, state_d;

  tone_sync_edge u_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .tone_i (TONE_IN),
    .edge_o (edge_s)
  );

  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_d   = edge_s ? '0 : (cnt_sat ? cnt_q : cnt_q + CNT_W'(1));

  // Measurement stage; the saturated flag forces a "none" classification.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      meas_q     <= '0;
      meas_sat_q <= 1'b0;
      meas_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      meas_vld_q <= edge_s;
      if (edge_s) begin
        meas_q     <= cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
        meas_sat_q <= cnt_sat;
      end
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    logic [EXT_W-1:0] meas_x, nom_x, diff_x;
    logic [3:0]       hits;
    cls_d  = NOTE_NONE;
    hits   = '0;
    meas_x = {1'b0, meas_q};
    for (int i = 1; i <= NUM_NOTES; i++) begin
      nom_x  = EXT_W'(nom_half_period(4'(i)) >> NOM_SHIFT);
      diff_x = (meas_x >= nom_x) ? meas_x - nom_x : nom_x - meas_x;
      if (diff_x <= (nom_x >> TOL_SHIFT)) begin
        hits  = hits + 4'd1;
        cls_d = 4'(i);
      end
    end
    if (hits != 4'd1 || meas_sat_q) cls_d = NOTE_NONE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cls_vld_q <= 1'b0;
      cls_q     <= NOTE_NONE;
    end else begin
      cls_vld_q <= meas_vld_q;
      if (meas_vld_q) cls_q <= cls_d;
    end
  end

  // A classified edge always beats saturation; the two cannot coincide anyway.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    code_d  = code_q;
    if (cls_vld_q) begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (cls_q != NOTE_NONE) begin
            state_d = ST_CONFIRM;
            cand_d  = cls_q;
          end
        end
        ST_CONFIRM: begin
          if (cls_q == NOTE_NONE) begin
            state_d = ST_ARM;
            code_d  = NOTE_NONE;
          end else if (cls_q == cand_q) begin
            state_d = ST_LOCKED;
            code_d  = cls_q;
          end else begin
            cand_d = cls_q;
          end
        end
        ST_LOCKED: begin
          if (cls_q == NOTE_NONE) begin
            state_d = ST_ARM;
            code_d  = NOTE_NONE;
          end else if (cls_q != code_q) begin
            state_d = ST_CONFIRM;
            cand_d  = cls_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (cnt_sat && !edge_s) begin
      state_d = ST_IDLE;
      code_d  = NOTE_NONE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cand_q   <= NOTE_NONE;
      code_q   <= NOTE_NONE;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= (code_d != NOTE_NONE);
      strobe_q <= (code_d != code_q);
    end
  end

  assign NOTE_CODE   = code_q;
  assign NOTE_VALID  = valid_q;
  assign NOTE_STROBE = strobe_q;

`ifdef NOTE_DETECT_DEBUG_EN
  assign HALF_PERIOD = meas_q;
`endif

endmodule
